// File: rtl/signal_control_sched.sv
// signal_control_sched: event scheduler for the signal-control path.
// Each asynchronous `signal` bit passes through a two-flop synchroniser.
// Edges on the synchronised bits are latched as pending events.
// Pending events are granted one at a time, round-robin, to the `control`
// channel using a valid/ready handshake. Every accepted grant is followed
// by a programmable holdoff gap of GAP cycles.
// Optional build macro: SIGNAL_SCHED_BOTH_EDGE_EN. When it is defined, both
// rising and falling edges generate events. By default only rising edges do.
module signal_control_sched #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int GAP = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   signal,
    input  logic           ready,
    output logic           control,
    output logic [IDW-1:0] control_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow
);

    localparam int unsigned NU = N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_q,      state_d;
    logic [N-1:0]   sync1_q,      sync1_d;
    logic [N-1:0]   sync2_q,      sync2_d;
    logic [N-1:0]   prev_q,       prev_d;
    logic [N-1:0]   pending_q,    pending_d;
    logic [N-1:0]   overflow_q,   overflow_d;
    logic           control_q,    control_d;
    logic [IDW-1:0] control_id_q, control_id_d;
    logic [IDW-1:0] ptr_q,        ptr_d;
    logic [7:0]     gap_cnt_q,    gap_cnt_d;

    logic [N-1:0]   ev;
    logic [N-1:0]   acc_vec;
    logic           accept;
    logic           sel_found;
    logic [IDW-1:0] sel_id;

    // Synchroniser chain, plus the previous synchronised value used for edge detection
    always_comb begin
        sync1_d = signal;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Event detection on the synchronised inputs
    always_comb begin
`ifdef SIGNAL_SCHED_BOTH_EDGE_EN
        ev = sync2_q ^ prev_q;
`else
        ev = sync2_q & ~prev_q;
`endif
    end

    // Pending/overflow bookkeeping.
    // An event coinciding with an accept on the same bit re-arms that bit
    // without flagging an overflow.
    always_comb begin
        accept  = control_q & ready;
        acc_vec = '0;
        if (accept) begin
            acc_vec[control_id_q] = 1'b1;
        end
        pending_d  = ev | (pending_q & ~acc_vec);
        overflow_d = overflow_q | (ev & pending_q & ~acc_vec);
    end

    // Round-robin pick: the first pending bit found scanning upward from ptr, wrapping at N
    always_comb begin
        int unsigned idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = (32'(ptr_q) + k) % NU;
            if (!sel_found && pending_q[idx]) begin
                sel_found = 1'b1;
                sel_id    = IDW'(idx);
            end
        end
    end

    // Grant FSM: next-state and registered grant outputs
    always_comb begin
        state_d      = state_q;
        control_d    = control_q;
        control_id_d = control_id_q;
        ptr_d        = ptr_q;
        gap_cnt_d    = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    control_d    = 1'b1;
                    control_id_d = sel_id;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ready) begin
                    control_d = 1'b0;
                    ptr_d     = (control_id_q == IDW'(N - 1)) ? '0 : control_id_q + 1'b1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = 8'(GAP);
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                control_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            control_q    <= 1'b0;
            control_id_q <= '0;
            ptr_q        <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            control_q    <= control_d;
            control_id_q <= control_id_d;
            ptr_q        <= ptr_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign control    = control_q;
    assign control_id = control_id_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_signal_control_sched.sv
// Testbench for signal_control_sched.
// A directed sequence covers reset, single event, round-robin order,
// backpressure, overflow, reset during a grant and the edge-mode build.
// A randomized tail follows. Every cycle, the DUT is compared against a
// reference model built from the input sample history and grant timing.
module tb_signal_control_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int GAP = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   sig;
    logic           rdy;
    logic           control;
    logic [IDW-1:0] control_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state.
    // h1/h2/h3 hold the signal sampled 1, 2 and 3 edges ago.
    logic [N-1:0] h1, h2, h3;
    logic [N-1:0] m_pend, m_ovf;
    logic         m_ctrl;
    int           m_id, m_ptr, m_next_arb;

    int acc_log[$];
    int acc_edge[$];

    always #5 clk = ~clk;

    signal_control_sched #(.N(N), .IDW(IDW), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (sig),
        .ready      (rdy),
        .control    (control),
        .control_id (control_id),
        .pending    (pending),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge, using the inputs present at that edge
    task automatic model_edge();
        logic [N-1:0] ev, accv, np, no;
        bit found;
        int idx;
        if (rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_pend = '0; m_ovf = '0;
            m_ctrl = 1'b0; m_id = 0; m_ptr = 0; m_next_arb = 0;
        end else begin
`ifdef SIGNAL_SCHED_BOTH_EDGE_EN
            ev = h2 ^ h3;
`else
            ev = h2 & ~h3;
`endif
            accv = '0;
            if (m_ctrl && rdy) accv[m_id] = 1'b1;
            np = ev | (m_pend & ~accv);
            no = m_ovf | (ev & m_pend & ~accv);
            if (m_ctrl) begin
                if (rdy) begin
                    m_ctrl     = 1'b0;
                    m_ptr      = (m_id + 1) % N;
                    m_next_arb = cyc + GAP + 1;
                end
            end else if (cyc >= m_next_arb && m_pend != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && m_pend[idx]) begin
                        found = 1;
                        m_id  = idx;
                    end
                end
                m_ctrl = 1'b1;
            end
            m_pend = np;
            m_ovf  = no;
            h3 = h2; h2 = h1; h1 = sig;
        end
    endtask

    // Called at a falling edge with the inputs already set. Runs one clock cycle.
    task automatic tick();
        if (control === 1'b1 && rdy) begin
            acc_log.push_back(int'(control_id));
            acc_edge.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("model_control", control, m_ctrl);
        check("model_control_id", control_id, m_id);
        check("model_pending", pending, m_pend);
        check("model_overflow", overflow, m_ovf);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n0;
        h1 = '0; h2 = '0; h3 = '0; m_pend = '0; m_ovf = '0;
        m_ctrl = 1'b0; m_id = 0; m_ptr = 0; m_next_arb = 0;
        rst = 1'b1; sig = '0; rdy = 1'b0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        check("reset_control", control, 0);
        check("reset_control_id", control_id, 0);
        check("reset_pending", pending, 0);
        check("reset_overflow", overflow, 0);
        tick(); tick();

        // Single event on bit 2
        rdy = 1'b1; sig = 4'b0100;
        tick(); tick(); tick();
        check("single_pending", pending, 4'b0100);
        check("single_ctrl_early", control, 0);
        n0 = acc_log.size();
        tick();
        check("single_ctrl", control, 1);
        check("single_id", control_id, 2);
        tick();
        check("single_ctrl_drop", control, 0);
        repeat (5) tick();
        sig = '0;
        repeat (10) tick();
        check("single_grants", acc_log.size() - n0, 1);
        check("single_pending_end", pending, 0);
        check("single_overflow_end", overflow, 0);

        // Round-robin across all four bits
        do_reset();
        n0 = acc_log.size();
        sig = 4'hF; rdy = 1'b1;
        repeat (30) tick();
        sig = '0;
        repeat (5) tick();
        check("rr_count", acc_log.size() - n0, 4);
        if (acc_log.size() - n0 == 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", acc_log[n0 + k], k);
            for (int k = 0; k < 3; k++)
                check("rr_spacing", acc_edge[n0 + k + 1] - acc_edge[n0 + k], GAP + 2);
        end
        n0 = acc_log.size();
        sig = 4'b0011;
        repeat (20) tick();
        sig = '0;
        repeat (5) tick();
        check("rr_wrap_count", acc_log.size() - n0, 2);
        if (acc_log.size() - n0 == 2) begin
            check("rr_wrap_first", acc_log[n0], 0);
            check("rr_wrap_second", acc_log[n0 + 1], 1);
        end

        // Backpressure on id 1
        rdy = 1'b0; sig = 4'b0010;
        repeat (4) tick();
        check("bp_ctrl", control, 1);
        check("bp_id", control_id, 1);
        n0 = acc_log.size();
        repeat (20) begin
            tick();
            check("bp_hold_ctrl", control, 1);
            check("bp_hold_id", control_id, 1);
        end
        rdy = 1'b1;
        tick();
        check("bp_accept_ctrl", control, 0);
        check("bp_accept_count", acc_log.size() - n0, 1);
        if (acc_log.size() > n0) check("bp_accept_id", acc_log[n0], 1);
        sig = '0;
        repeat (6) tick();

        // Overflow: two rising edges on bit 0 while the downstream stalls
        rdy = 1'b0;
        sig = 4'b0001; tick(); tick();
        sig = '0;      tick(); tick();
        sig = 4'b0001; tick(); tick();
        sig = '0;
        repeat (6) tick();
        check("ovf_flag", overflow, 4'b0001);
        check("ovf_pending", pending, 4'b0001);
        n0 = acc_log.size();
        rdy = 1'b1;
        repeat (15) tick();
        check("ovf_grants", acc_log.size() - n0, 1);
        check("ovf_sticky", overflow, 4'b0001);
        check("ovf_pending_clear", pending, 0);

        // Reset asserted while a grant is outstanding
        rdy = 1'b0;
        sig = 4'b1000; tick(); tick();
        sig = '0;
        repeat (4) tick();
        check("rst_mid_pre_ctrl", control, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ctrl", control, 0);
        check("rst_mid_pending", pending, 0);
        check("rst_mid_overflow", overflow, 0);
        check("rst_mid_id", control_id, 0);
        n0 = acc_log.size();
        rdy = 1'b1;
        repeat (15) tick();
        check("rst_mid_no_grant", acc_log.size() - n0, 0);

        // A single pulse on bit 1; the number of grants depends on the edge mode
        n0 = acc_log.size();
        sig = 4'b0010;
        repeat (4) tick();
        sig = '0;
        repeat (30) tick();
`ifdef SIGNAL_SCHED_BOTH_EDGE_EN
        check("pulse_grants", acc_log.size() - n0, 2);
`else
        check("pulse_grants", acc_log.size() - n0, 1);
`endif
        if (acc_log.size() > n0) check("pulse_id", acc_log[acc_log.size() - 1], 1);

        // Randomized traffic with occasional resets
        repeat (400) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) sig[b] = ~sig[b];
            rdy = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
